// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state type, default constants and source-index helpers
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPENING   = 2'd1,
    WAIT_PASS = 2'd2,
    CLOSING   = 2'd3
  } state_t;

  localparam int DEF_TOTAL_SPOTS    = 8;
  localparam int DEF_OPEN_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Source layout: indices [0, nl) are lane exits, [nl, 2*nl) are lane entries.
  function automatic int exit_src(input int lane);
    return lane;
  endfunction

  function automatic int enter_src(input int lane, input int nl);
    return nl + lane;
  endfunction

  function automatic logic src_is_exit(input int idx, input int nl);
    return (idx < nl);
  endfunction

  function automatic int src_lane(input int idx, input int nl);
    return (idx < nl) ? idx : idx - nl;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module rr_arbiter #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // Scan from the far end back toward ptr so the requester closest to ptr is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        winner = IW'((int'(ptr) + k) % N);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// rtl/parking_gate_scheduler.sv - lane arbiter, barrier sequencer and free-spot owner (option: PARKING_TIMEOUT_EN)
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TOTAL_SPOTS    = DEF_TOTAL_SPOTS,
  parameter int CNT_W          = 8,
  parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] enter_req,
  input  logic [NUM_LANES-1:0] exit_req,
  input  logic [NUM_LANES-1:0] passed,
  output logic                 grant_valid,
  output logic [LW-1:0]        grant_lane,
  output logic                 grant_is_exit,
  output logic [NUM_LANES-1:0] gate_open,
  output logic [CNT_W-1:0]     free_spots,
  output logic                 full,
  output logic                 empty,
  output logic                 timeout
);

  localparam int NSRC = 2 * NUM_LANES;
  localparam int SW   = $clog2(NSRC);
  localparam int MAXC = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
  localparam int PW   = $clog2(MAXC + 1);

  state_t               state, state_n;
  logic [PW-1:0]        cnt, cnt_n;
  logic [SW-1:0]        rr_ptr, rr_ptr_n;
  logic [NSRC-1:0]      src;
  logic [SW-1:0]        win;
  logic                 win_valid;
  logic                 pass_hit;
  logic                 grant_valid_n, grant_is_exit_n, timeout_n;
  logic [LW-1:0]        grant_lane_n;
  logic [NUM_LANES-1:0] gate_open_n;
  logic [CNT_W-1:0]     free_spots_n;

  assign full     = (free_spots == '0);
  assign empty    = (free_spots == CNT_W'(TOTAL_SPOTS));
  assign pass_hit = passed[grant_lane];

  // Build the eligible source vector: entries blocked when full, exits blocked when empty.
  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      src[exit_src(i)]             = exit_req[i] & ~empty;
      src[enter_src(i, NUM_LANES)] = enter_req[i] & ~full;
    end
  end

  rr_arbiter #(.N(NSRC)) u_arb (
    .req    (src),
    .ptr    (rr_ptr),
    .winner (win),
    .valid  (win_valid)
  );

  // Next-state, next-count and next-output decode for the barrier sequence.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    rr_ptr_n        = rr_ptr;
    grant_lane_n    = grant_lane;
    grant_is_exit_n = grant_is_exit;
    free_spots_n    = free_spots;
    timeout_n       = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_n         = OPENING;
          cnt_n           = '0;
          grant_lane_n    = LW'(src_lane(int'(win), NUM_LANES));
          grant_is_exit_n = src_is_exit(int'(win), NUM_LANES);
          rr_ptr_n        = (win == SW'(NSRC - 1)) ? '0 : win + SW'(1);
        end
      end
      OPENING: begin
        if (cnt == PW'(OPEN_CYCLES - 1)) begin
          state_n = WAIT_PASS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + PW'(1);
        end
      end
      WAIT_PASS: begin
        if (pass_hit) begin
          state_n      = CLOSING;
          cnt_n        = '0;
          free_spots_n = grant_is_exit ? free_spots + CNT_W'(1) : free_spots - CNT_W'(1);
        end
`ifdef PARKING_TIMEOUT_EN
        else if (cnt == PW'(TIMEOUT_CYCLES - 1)) begin
          state_n   = CLOSING;
          cnt_n     = '0;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + PW'(1);
        end
`endif
      end
      CLOSING: begin
        if (cnt == PW'(OPEN_CYCLES - 1)) begin
          state_n         = IDLE;
          cnt_n           = '0;
          grant_lane_n    = '0;
          grant_is_exit_n = 1'b0;
        end else begin
          cnt_n = cnt + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    grant_valid_n = (state_n != IDLE);
    gate_open_n   = (state_n == OPENING || state_n == WAIT_PASS) ?
                    (NUM_LANES'(1) << grant_lane_n) : '0;
  end

  // Register state and every output; reset abandons any transaction and restores capacity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      free_spots    <= CNT_W'(TOTAL_SPOTS);
      grant_valid   <= 1'b0;
      grant_lane    <= '0;
      grant_is_exit <= 1'b0;
      gate_open     <= '0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rr_ptr        <= rr_ptr_n;
      free_spots    <= free_spots_n;
      grant_valid   <= grant_valid_n;
      grant_lane    <= grant_lane_n;
      grant_is_exit <= grant_is_exit_n;
      gate_open     <= gate_open_n;
      timeout       <= timeout_n;
    end
  end

  // The count must stay within capacity; masking of full/empty makes wrap impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (free_spots <= CNT_W'(TOTAL_SPOTS));
  end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb/tb_parking_gate_scheduler.sv - directed scoreboard bench for parking_gate_scheduler
module tb_parking_gate_scheduler;

  localparam int NL     = 4;
  localparam int TOTAL  = 8;
  localparam int OPEN_C = 2;
  localparam int TMO    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NL-1:0] enter_req = '0;
  logic [NL-1:0] exit_req = '0;
  logic [NL-1:0] passed = '0;
  logic          grant_valid;
  logic [1:0]    grant_lane;
  logic          grant_is_exit;
  logic [NL-1:0] gate_open;
  logic [7:0]    free_spots;
  logic          full;
  logic          empty;
  logic          timeout;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int lane;
    bit is_exit;
    int spots;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  parking_gate_scheduler #(
    .NUM_LANES      (NL),
    .TOTAL_SPOTS    (TOTAL),
    .CNT_W          (8),
    .OPEN_CYCLES    (OPEN_C),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enter_req     (enter_req),
    .exit_req      (exit_req),
    .passed        (passed),
    .grant_valid   (grant_valid),
    .grant_lane    (grant_lane),
    .grant_is_exit (grant_is_exit),
    .gate_open     (gate_open),
    .free_spots    (free_spots),
    .full          (full),
    .empty         (empty),
    .timeout       (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enter_req = '0;
    exit_req  = '0;
    passed    = '0;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output exp_t e);
    int n;
    n = 0;
    while (grant_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("grant_valid_rise", grant_valid, 1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{lane: -1, is_exit: 1'b0, spots: -1};
    chk("grant_lane", grant_lane, e.lane);
    chk("grant_is_exit", grant_is_exit, e.is_exit);
    chk("gate_open_grant", gate_open, (e.lane >= 0) ? (1 << e.lane) : 0);
  endtask

  task automatic finish_pass(input exp_t e, input int delay);
    int n;
    repeat (delay) tick();
    chk("gate_open_wait", gate_open, (e.lane >= 0) ? (1 << e.lane) : 0);
    if (e.lane >= 0) begin
      passed[e.lane] = 1'b1;
      if (e.is_exit) exit_req[e.lane] = 1'b0;
      else enter_req[e.lane] = 1'b0;
    end
    tick();
    passed = '0;
    chk("gate_open_closed", gate_open, 0);
    chk("free_spots_after", free_spots, e.spots);
    n = 0;
    while (grant_valid === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_valid_fall", grant_valid, 0);
    chk("closing_len", n, OPEN_C);
  endtask

  task automatic serve(input int delay);
    exp_t e;
    wait_grant(e);
    repeat (OPEN_C) tick();
    finish_pass(e, delay);
  endtask

  initial begin
    exp_t e;
    int   gv_cnt;
    int   go_cnt;

    // Reset state
    do_reset();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_lane", grant_lane, 0);
    chk("rst_grant_is_exit", grant_is_exit, 0);
    chk("rst_gate_open", gate_open, 0);
    chk("rst_free_spots", free_spots, TOTAL);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_timeout", timeout, 0);

    // Single entry on lane 1, pass in the first WAIT_PASS cycle
    enter_req[1] = 1'b1;
    tick();
    gv_cnt = 0;
    go_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) chk("single_lane", grant_lane, 1);
      if (grant_valid === 1'b1) gv_cnt++;
      if (gate_open === 4'b0010) go_cnt++;
      passed[1] = (c == OPEN_C);
      if (c == OPEN_C) enter_req[1] = 1'b0;
      tick();
    end
    passed = '0;
    chk("single_gate_cycles", go_cnt, OPEN_C + 1);
    chk("single_grant_cycles", gv_cnt, 2 * OPEN_C + 1);
    chk("single_free_spots", free_spots, TOTAL - 1);

    // Round-robin from a fresh pointer: lanes 0..3 in order
    do_reset();
    enter_req = 4'b1111;
    for (int i = 0; i < NL; i++) sb.push_back('{lane: i, is_exit: 1'b0, spots: TOTAL - 1 - i});
    for (int i = 0; i < NL; i++) serve(i % 3);
    chk("rr_free_spots", free_spots, 4);

    // Fill to zero, then the exit wins over the masked entry
    for (int i = 0; i < 4; i++) begin
      enter_req[0] = 1'b1;
      sb.push_back('{lane: 0, is_exit: 1'b0, spots: 3 - i});
      serve(0);
    end
    chk("lock_full", full, 1);
    chk("lock_empty", empty, 0);
    enter_req[2] = 1'b1;
    exit_req[3]  = 1'b1;
    sb.push_back('{lane: 3, is_exit: 1'b1, spots: 1});
    sb.push_back('{lane: 2, is_exit: 1'b0, spots: 0});
    serve(1);
    serve(0);

    // Stray passes: wrong lane during WAIT_PASS, granted lane while IDLE
    exit_req[2] = 1'b1;
    sb.push_back('{lane: 2, is_exit: 1'b1, spots: 1});
    wait_grant(e);
    repeat (OPEN_C) tick();
    passed[0] = 1'b1;
    tick();
    passed = '0;
    chk("stray_free_spots", free_spots, 0);
    chk("stray_gate_open", gate_open, 4'b0100);
    chk("stray_grant_valid", grant_valid, 1);
    finish_pass(e, 1);
    passed[2] = 1'b1;
    tick();
    passed = '0;
    chk("idle_pass_free_spots", free_spots, 1);
    chk("idle_pass_grant_valid", grant_valid, 0);

`ifdef PARKING_TIMEOUT_EN
    // Exit lane 0 never passes: timeout after TMO WAIT_PASS cycles
    exit_req[0] = 1'b1;
    sb.push_back('{lane: 0, is_exit: 1'b1, spots: 1});
    wait_grant(e);
    repeat (OPEN_C) tick();
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", timeout, 0);
    chk("tmo_gate_still_open", gate_open, 4'b0001);
    tick();
    chk("tmo_pulse", timeout, 1);
    chk("tmo_gate_closed", gate_open, 0);
    chk("tmo_free_spots", free_spots, e.spots);
    exit_req[0] = 1'b0;
    tick();
    chk("tmo_pulse_end", timeout, 0);
    repeat (OPEN_C) tick();
    chk("tmo_back_idle", grant_valid, 0);
`else
    chk("no_timeout", timeout, 0);
`endif

    // Reset in WAIT_PASS with five spots free
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enter_req[1] = 1'b1;
      sb.push_back('{lane: 1, is_exit: 1'b0, spots: TOTAL - 1 - i});
      serve(i);
    end
    enter_req[2] = 1'b1;
    sb.push_back('{lane: 2, is_exit: 1'b0, spots: 4});
    wait_grant(e);
    repeat (OPEN_C) tick();
    chk("mid_free_before", free_spots, 5);
    chk("mid_gate_before", gate_open, 4'b0100);
    reset = 1'b1;
    tick();
    chk("mid_gate_open", gate_open, 0);
    chk("mid_grant_valid", grant_valid, 0);
    chk("mid_free_spots", free_spots, TOTAL);
    chk("mid_grant_lane", grant_lane, 0);
    enter_req = 4'b1001;
    tick();
    reset = 1'b0;
    // A cleared pointer serves lane 0 before lane 3
    sb.push_back('{lane: 0, is_exit: 1'b0, spots: TOTAL - 1});
    sb.push_back('{lane: 3, is_exit: 1'b0, spots: TOTAL - 2});
    serve(0);
    serve(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
